clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Consumes the one-cycle key-press pulses produced by the batch debouncer and
//  turns them into the clock's time-setting user interface. Runs an edit FSM
//  (enter set mode, select field, increment/decrement with wrap, commit/abort).
//  Presents edited H/M/S values plus a one-cycle load strobe to the time counter.
//  Drives blink controls to the display.
// PARAMETERS
//  TIMEOUT_CYCLES  250_000_000  idle cycles in a set state before abort (>=2)
//  BLINK_CYCLES    25_000_000   half-period of blink toggle, in clk cycles (>=1)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  key_pulse    in   4   1-cycle press pulses: [0]MODE [1]NEXT [2]UP [3]DOWN
//  cur_hour     in   5   running hour 0..23
//  cur_min      in   6   running minute 0..59
//  cur_sec      in   6   running second 0..59
//  set_mode     out  1   1 while in any SET_* state
//  field_sel    out  3   one-hot edited field: [2]hour [1]min [0]sec; 0 in RUN
//  edit_hour    out  5   edited hour
//  edit_min     out  6   edited minute
//  edit_sec     out  6   edited second
//  load         out  1   1-cycle strobe: time counter loads edit_* values
//  blink        out  1   blink phase for the selected field; 0 outside set mode
// BEHAVIOUR
//  Reset (async, rst_n=0): state RUN; all outputs 0; timeout/blink counters 0.
//  States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT. All outputs registered.
//  Key decode per cycle, single winner, priority MODE > NEXT > UP > DOWN.
//   UP and DOWN in the same cycle (no MODE/NEXT): no action, still counts as key.
//  RUN: MODE -> capture cur_hour/min/sec into edit_*, go SET_HOUR. Other keys ignored.
//  SET_x: NEXT -> HOUR->MIN->SEC->HOUR; UP/DOWN -> +1/-1 on selected field.
//   Wrap: hour 23+1=0, 0-1=23; min/sec 59+1=0, 0-1=59. Other fields untouched.
//   MODE -> COMMIT.
//  COMMIT: load=1 for exactly this one cycle, edit_* stable; next cycle RUN.
//   Key pulses arriving in COMMIT are dropped.
//  Latency: key pulse sampled at edge N -> state/edit_*/field_sel valid after N.
//   MODE in SET_x at edge N -> load high in cycle after N, RUN after N+1.
//  Timeout: counter clears on any key pulse (any bit) and on SET_x entry;
//   increments every cycle in SET_x; reaching TIMEOUT_CYCLES-1 -> RUN, no load,
//   edit_* retain last values. Counter idle (0) in RUN/COMMIT.
//  Blink: counter runs only in SET_x; toggles blink every BLINK_CYCLES;
//   blink and counter cleared on SET_x entry and on every UP/DOWN/NEXT action
//   (blink=0 means field visible). Forced 0 in RUN/COMMIT.
//  field_sel: 3'b100/010/001 for SET_HOUR/MIN/SEC; 0 in RUN and COMMIT.
//  set_mode = 1 in SET_HOUR/MIN/SEC only.
//  edit_* hold value in RUN (not tracking cur_*); refreshed only on MODE entry.
//  Out-of-range cur_* inputs are captured as-is; first UP/DOWN wraps to 0 / max.
//  Reset mid-edit: immediate RUN, no load pulse, edits discarded (edit_*=0).
//  Counter widths from $clog2 of the parameters; no truncation on compare.
// TESTING
//  1 Reset, cur=12:34:56, MODE -> set_mode=1, field_sel=100, edit=12:34:56.
//  2 In SET_HOUR edit=23, UP -> 0; DOWN -> 23; NEXT,DOWN on min 0 -> 59;
//    NEXT to sec 59, UP -> 0; NEXT returns to field_sel=100.
//  3 Edit to 08:15:00, MODE -> load=1 exactly 1 cycle with 08:15:00, then RUN.
//  4 TIMEOUT_CYCLES=16: enter set, no keys 15 cycles -> RUN, load never 1;
//    key at cycle 10 restarts count.
//  5 key_pulse=4'b1110 in SET_MIN -> NEXT wins (SET_SEC, no value change);
//    4'b1100 -> no change; pulse during COMMIT ignored.
//  6 Assert rst_n low mid-SET_MIN -> all outputs 0 asynchronously, no load.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Purpose: bundles key pulses, running time and the edit/display outputs of clock_set_ctrl.
// Latency: none, wiring only.
// Backpressure: none, pulses and levels only.
interface clock_set_ctrl_if;
  logic [3:0] key_pulse;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       set_mode;
  logic [2:0] field_sel;
  logic [4:0] edit_hour;
  logic [5:0] edit_min;
  logic [5:0] edit_sec;
  logic       load;
  logic       blink;

  // Keypad/time-counter side: drives keys and running time, observes the editor.
  modport master (
    output key_pulse, cur_hour, cur_min, cur_sec,
    input  set_mode, field_sel, edit_hour, edit_min, edit_sec, load, blink
  );

  // Editor side.
  modport slave (
    input  key_pulse, cur_hour, cur_min, cur_sec,
    output set_mode, field_sel, edit_hour, edit_min, edit_sec, load, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Purpose: time-setting editor FSM driven by debounced key pulses (MODE/NEXT/UP/DOWN).
// Latency: key sampled at edge N is reflected on all (registered) outputs after edge N.
// Backpressure: none; pulses in COMMIT are dropped, idle set mode aborts after TIMEOUT_CYCLES.
module clock_set_ctrl #(
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int BLINK_CYCLES   = 25_000_000
) (
  input logic            clk,
  input logic            rst_n,
  clock_set_ctrl_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  // The abort edge is the one at which the idle count would reach TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          blink_q, blink_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          set_mode_q, set_mode_d;
  logic [2:0]    field_sel_q, field_sel_d;
  logic          load_q, load_d;
  logic          in_set_q, in_set_d;
  logic          k_any, k_mode, k_next, k_up, k_dn;

  // Out-of-range values wrap to 0 on increment and to the maximum on decrement.
  function automatic logic [5:0] wrap_up(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dn(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0 || v > top) ? top : v - 6'd1;
  endfunction

  // Single-winner key decode: MODE > NEXT > UP > DOWN; UP+DOWN together is a no-op.
  always_comb begin
    k_any  = |bus.key_pulse;
    k_mode = bus.key_pulse[0];
    k_next = bus.key_pulse[1] & ~bus.key_pulse[0];
    k_up   = bus.key_pulse[2] & ~bus.key_pulse[3] & ~bus.key_pulse[1] & ~bus.key_pulse[0];
    k_dn   = bus.key_pulse[3] & ~bus.key_pulse[2] & ~bus.key_pulse[1] & ~bus.key_pulse[0];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: if (k_mode) state_d = SET_HOUR;
      SET_HOUR, SET_MIN, SET_SEC: begin
        if (k_mode)
          state_d = COMMIT;
        else if (k_next)
          state_d = (state_q == SET_HOUR) ? SET_MIN :
                    (state_q == SET_MIN)  ? SET_SEC : SET_HOUR;
        else if (!k_any && tmo_q == TMO_LAST)
          state_d = RUN;
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Edit values, idle timeout and blink phase for the next cycle.
  always_comb begin
    in_set_q  = (state_q == SET_HOUR) || (state_q == SET_MIN) || (state_q == SET_SEC);
    in_set_d  = (state_d == SET_HOUR) || (state_d == SET_MIN) || (state_d == SET_SEC);
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    tmo_d     = '0;
    blk_cnt_d = '0;
    blink_d   = 1'b0;

    if (state_q == RUN && k_mode) begin
      hour_d = bus.cur_hour;
      min_d  = bus.cur_min;
      sec_d  = bus.cur_sec;
    end else if (in_set_q && (k_up || k_dn)) begin
      if (state_q == SET_HOUR)
        hour_d = k_up ? 5'(wrap_up({1'b0, hour_q}, 6'd23)) : 5'(wrap_dn({1'b0, hour_q}, 6'd23));
      else if (state_q == SET_MIN)
        min_d = k_up ? wrap_up(min_q, 6'd59) : wrap_dn(min_q, 6'd59);
      else
        sec_d = k_up ? wrap_up(sec_q, 6'd59) : wrap_dn(sec_q, 6'd59);
    end

    // Counters only run while staying in set mode; entry and exit leave them cleared.
    if (in_set_q && in_set_d) begin
      if (!k_any)
        tmo_d = tmo_q + TW'(1);
      if (!(k_next || k_up || k_dn)) begin
        if (blk_cnt_q == BLK_LAST) begin
          blink_d = ~blink_q;
        end else begin
          blk_cnt_d = blk_cnt_q + BW'(1);
          blink_d   = blink_q;
        end
      end
    end
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    set_mode_d  = in_set_d;
    load_d      = (state_d == COMMIT);
    field_sel_d = (state_d == SET_HOUR) ? 3'b100 :
                  (state_d == SET_MIN)  ? 3'b010 :
                  (state_d == SET_SEC)  ? 3'b001 : 3'b000;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      blk_cnt_q   <= '0;
      blink_q     <= 1'b0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      set_mode_q  <= 1'b0;
      field_sel_q <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      blk_cnt_q   <= blk_cnt_d;
      blink_q     <= blink_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      set_mode_q  <= set_mode_d;
      field_sel_q <= field_sel_d;
      load_q      <= load_d;
    end
  end

  assign bus.set_mode  = set_mode_q;
  assign bus.field_sel = field_sel_q;
  assign bus.edit_hour = hour_q;
  assign bus.edit_min  = min_q;
  assign bus.edit_sec  = sec_q;
  assign bus.load      = load_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Purpose: self-checking bench for clock_set_ctrl (vector table, corner sequences, random vs model).
// Latency: inputs driven on the falling edge, outputs checked on the next falling edge.
// Backpressure: none.
module tb_clock_set_ctrl;
  localparam int TMO = 16;
  localparam int BLK = 3;
  localparam logic [3:0] KM = 4'b0001, KN = 4'b0010, KU = 4'b0100, KD = 4'b1000, K0 = 4'b0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.TIMEOUT_CYCLES(TMO), .BLINK_CYCLES(BLK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic [4:0] ch;
    logic [5:0] cm;
    logic [5:0] cs;
    logic       sm;
    logic [2:0] fs;
    logic [4:0] eh;
    logic [5:0] em;
    logic [5:0] es;
    logic       ld;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] key, input int ch, input int cm, input int cs,
                     input logic sm, input logic [2:0] fs, input int eh, input int em,
                     input int es, input logic ld);
    vec_t v;
    v.key = key; v.ch = 5'(ch); v.cm = 6'(cm); v.cs = 6'(cs);
    v.sm = sm; v.fs = fs; v.eh = 5'(eh); v.em = 6'(em); v.es = 6'(es); v.ld = ld;
    tbl.push_back(v);
  endtask

  // Behavioural model: editor is either idle, editing field fld (2=hour,1=min,0=sec) or committing.
  bit       m_set, m_commit, m_blink;
  int       fld, idle, bcnt;
  int       m_h, m_m, m_s;

  task automatic model_reset();
    m_set = 0; m_commit = 0; m_blink = 0;
    fld = 2; idle = 0; bcnt = 0;
    m_h = 0; m_m = 0; m_s = 0;
  endtask

  function automatic int bump(input int v, input int top, input bit up);
    if (up) return (v >= top) ? 0 : v + 1;
    return (v == 0 || v > top) ? top : v - 1;
  endfunction

  task automatic model_step(input logic [3:0] k);
    bit up_only, dn_only;
    up_only = (k == KU);
    dn_only = (k == KD);
    if (m_commit) begin
      m_commit = 0;
    end else if (!m_set) begin
      if (k[0]) begin
        m_h = int'(bus.cur_hour); m_m = int'(bus.cur_min); m_s = int'(bus.cur_sec);
        m_set = 1; fld = 2; idle = 0; bcnt = 0; m_blink = 0;
      end
    end else if (k[0]) begin
      m_set = 0; m_commit = 1;
    end else begin
      if (k[1]) fld = (fld == 0) ? 2 : fld - 1;
      else if (up_only || dn_only) begin
        if (fld == 2) m_h = bump(m_h, 23, up_only);
        else if (fld == 1) m_m = bump(m_m, 59, up_only);
        else m_s = bump(m_s, 59, up_only);
      end
      if (k[1] || up_only || dn_only) begin
        bcnt = 0; m_blink = 0;
      end else begin
        bcnt++;
        if (bcnt == BLK) begin bcnt = 0; m_blink = !m_blink; end
      end
      if (k != 0) idle = 0;
      else begin
        idle++;
        if (idle == TMO - 1) m_set = 0;
      end
    end
  endtask

  task automatic check_model(input string name);
    logic [28:0] got, exp;
    got = {bus.set_mode, bus.field_sel, bus.edit_hour, bus.edit_min, bus.edit_sec, bus.load, bus.blink};
    exp = {m_set, m_set ? 3'(1 << fld) : 3'b000, 5'(m_h), 6'(m_m), 6'(m_s), m_commit, m_set & m_blink};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got sm=%0b fs=%03b %0d:%0d:%0d ld=%0b bl=%0b, expected sm=%0b fs=%03b %0d:%0d:%0d ld=%0b bl=%0b",
               name, got[28], got[27:25], got[24:20], got[19:14], got[13:8], got[1], got[0],
               exp[28], exp[27:25], exp[24:20], exp[19:14], exp[13:8], exp[1], exp[0]);
    end
  endtask

  task automatic expect_val(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One cycle: present key at the falling edge, let the rising edge sample it, return at the next falling edge.
  task automatic tick(input logic [3:0] k);
    bus.key_pulse = k;
    @(posedge clk);
    model_step(k);
    @(negedge clk);
    bus.key_pulse = K0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hour = 5'(h); bus.cur_min = 6'(m); bus.cur_sec = 6'(s);
  endtask

  task automatic do_reset();
    bus.key_pulse = K0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    bus.key_pulse = K0;
    set_cur(12, 34, 56);

    // key, cur h/m/s, expected set_mode, field_sel, edit h/m/s, load
    add(K0, 12, 34, 56, 0, 3'b000,  0,  0,  0, 0);
    add(KM, 12, 34, 56, 1, 3'b100, 12, 34, 56, 0);
    add(KM, 12, 34, 56, 0, 3'b000, 12, 34, 56, 1);
    add(K0, 12, 34, 56, 0, 3'b000, 12, 34, 56, 0);
    add(KM, 23,  0, 59, 1, 3'b100, 23,  0, 59, 0);
    add(KU, 23,  0, 59, 1, 3'b100,  0,  0, 59, 0);
    add(KD, 23,  0, 59, 1, 3'b100, 23,  0, 59, 0);
    add(KN, 23,  0, 59, 1, 3'b010, 23,  0, 59, 0);
    add(KD, 23,  0, 59, 1, 3'b010, 23, 59, 59, 0);
    add(KN, 23,  0, 59, 1, 3'b001, 23, 59, 59, 0);
    add(KU, 23,  0, 59, 1, 3'b001, 23, 59,  0, 0);
    add(KN, 23,  0, 59, 1, 3'b100, 23, 59,  0, 0);
    add(KM, 23,  0, 59, 0, 3'b000, 23, 59,  0, 1);
    add(K0,  7, 16,  1, 0, 3'b000, 23, 59,  0, 0);
    add(KM,  7, 16,  1, 1, 3'b100,  7, 16,  1, 0);
    add(KU,  7, 16,  1, 1, 3'b100,  8, 16,  1, 0);
    add(KN,  7, 16,  1, 1, 3'b010,  8, 16,  1, 0);
    add(KD,  7, 16,  1, 1, 3'b010,  8, 15,  1, 0);
    add(KN,  7, 16,  1, 1, 3'b001,  8, 15,  1, 0);
    add(KD,  7, 16,  1, 1, 3'b001,  8, 15,  0, 0);
    add(KM,  7, 16,  1, 0, 3'b000,  8, 15,  0, 1);
    add(K0,  7, 16,  1, 0, 3'b000,  8, 15,  0, 0);
    add(KU, 10, 20, 30, 0, 3'b000,  8, 15,  0, 0);
    add(KM, 10, 20, 30, 1, 3'b100, 10, 20, 30, 0);
    add(KN, 10, 20, 30, 1, 3'b010, 10, 20, 30, 0);
    add(4'b1110, 10, 20, 30, 1, 3'b001, 10, 20, 30, 0);
    add(4'b1100, 10, 20, 30, 1, 3'b001, 10, 20, 30, 0);
    add(KM, 10, 20, 30, 0, 3'b000, 10, 20, 30, 1);
    add(KM, 10, 20, 30, 0, 3'b000, 10, 20, 30, 0);
    add(K0, 10, 20, 30, 0, 3'b000, 10, 20, 30, 0);
    add(KM, 30, 62, 60, 1, 3'b100, 30, 62, 60, 0);
    add(KU, 30, 62, 60, 1, 3'b100,  0, 62, 60, 0);
    add(KN, 30, 62, 60, 1, 3'b010,  0, 62, 60, 0);
    add(KD, 30, 62, 60, 1, 3'b010,  0, 59, 60, 0);
    add(KN, 30, 62, 60, 1, 3'b001,  0, 59, 60, 0);
    add(KU, 30, 62, 60, 1, 3'b001,  0, 59,  0, 0);

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      logic [22:0] got, exp;
      set_cur(int'(tbl[i].ch), int'(tbl[i].cm), int'(tbl[i].cs));
      tick(tbl[i].key);
      got = {bus.set_mode, bus.field_sel, bus.edit_hour, bus.edit_min, bus.edit_sec, bus.load};
      exp = {tbl[i].sm, tbl[i].fs, tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].ld};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL vec%0d: got sm=%0b fs=%03b %0d:%0d:%0d ld=%0b, expected sm=%0b fs=%03b %0d:%0d:%0d ld=%0b",
                 i, got[22], got[21:19], got[18:14], got[13:8], got[7:2], got[0],
                 exp[22], exp[21:19], exp[18:14], exp[13:8], exp[7:2], exp[0]);
      end
    end

    // Idle timeout and blink phase.
    do_reset();
    set_cur(1, 2, 3);
    tick(KM);
    check_model("tmo_enter");
    for (int i = 1; i <= TMO - 2; i++) begin
      tick(K0);
      check_model("tmo_idle");
      if (i == BLK) expect_val("blink_on", int'(bus.blink), 1);
    end
    expect_val("tmo_still_set", int'(bus.set_mode), 1);
    tick(K0);
    expect_val("tmo_exit", int'(bus.set_mode), 0);
    expect_val("tmo_no_load", int'(bus.load), 0);
    expect_val("tmo_retain", int'({bus.edit_hour, bus.edit_min, bus.edit_sec}), int'({5'd1, 6'd2, 6'd3}));
    check_model("tmo_after");
    tick(K0);
    check_model("tmo_run");

    tick(KM);
    repeat (9) tick(K0);
    tick(KU);
    expect_val("blink_clear", int'(bus.blink), 0);
    for (int i = 1; i <= TMO - 2; i++) begin
      tick(K0);
      check_model("tmo_restart");
    end
    expect_val("tmo_restart_set", int'(bus.set_mode), 1);
    tick(K0);
    expect_val("tmo_restart_exit", int'(bus.set_mode), 0);
    expect_val("tmo_restart_hour", int'(bus.edit_hour), 2);

    // Asynchronous reset in the middle of editing minutes.
    do_reset();
    set_cur(5, 6, 7);
    tick(KM);
    tick(KN);
    check_model("pre_rst");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk);
    check_model("async_rst_hold");
    rst_n = 1'b1;
    tick(K0);
    check_model("post_rst");

    // Random keys against the model, busy then sparse so timeouts occur.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] k;
      if ($urandom_range(0, 7) == 0)
        set_cur(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      if ($urandom_range(0, 99) < ((i < 1500) ? 30 : 5))
        k = 4'($urandom_range(1, 15));
      else
        k = K0;
      tick(k);
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
